sram_ctrl_param: RTL and testbench

Parametrised controller that maps a wide host word (DATA_W) onto a narrower asynchronous SRAM (SRAM_DW, IS61WV25616-class, 16-bit default) by sequencing several SRAM beats per request. It has programmable access wait states, per-byte write masking with skipping of empty write beats, and a ready/ack handshake. It sits between the core's LSU/bus fabric and the board SRAM pins and generalises the fixed 32b/16b controller.

---
 rtl/sram_ctrl_param.sv | 247 ++++++++++++++++++++++++
 tb/tb_sram_ctrl_param.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl_param.sv
// sram_ctrl_param
//   Maps a DATA_W host word onto a 16-bit asynchronous SRAM. Each request runs
//   BEATS = DATA_W/SRAM_DW half-word beats. Every beat has a strobe of
//   WAIT_CYC+1 cycles followed by one recovery cycle. On a write, a beat whose
//   two byte enables are both 0 is skipped.
//
//   Ports
//     i_clk, i_reset          clock, asynchronous active-low reset
//     i_ADDR/i_WDATA/i_BMASK  host word address, write data, byte enables
//     i_WREN/i_RDEN           request strobes (a write wins if both are set)
//     o_READY/o_ACK/o_RDATA   accept flag, completion pulse, read word
//     SRAM_*                  SRAM pins (controls are active low)
//
//   Optional build macro SRAM_CTRL_REQBUF_EN adds a one-entry request buffer.
//   With it, o_READY means "buffer empty", and a buffered request starts
//   right after DONE.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | no request; CE_N high, DQ released
//   SETUP   | request latched; first beat address presented with CE_N high
//   STROBE  | CE_N low plus OE_N (read) or WE_N (write) low, WAIT_CYC+1 cycles
//   RECOV   | CE_N low, WE_N/OE_N high, address and write data held
//   DONE    | o_ACK pulse; read word is visible on o_RDATA
module sram_ctrl_param #(
   parameter int DATA_W   = 32,
   parameter int SRAM_DW  = 16,
   parameter int ADDR_W   = 17,
   parameter int WAIT_CYC = 1
) (
   input  logic                                        i_clk,
   input  logic                                        i_reset,
   input  logic [ADDR_W-1:0]                           i_ADDR,
   input  logic [DATA_W-1:0]                           i_WDATA,
   input  logic [DATA_W/8-1:0]                         i_BMASK,
   input  logic                                        i_WREN,
   input  logic                                        i_RDEN,
   output logic                                        o_READY,
   output logic [DATA_W-1:0]                           o_RDATA,
   output logic                                        o_ACK,
   output logic [ADDR_W+$clog2(DATA_W/SRAM_DW)-1:0]    SRAM_ADDR,
   inout  wire  [SRAM_DW-1:0]                          SRAM_DQ,
   output logic                                        SRAM_CE_N,
   output logic                                        SRAM_WE_N,
   output logic                                        SRAM_OE_N,
   output logic                                        SRAM_LB_N,
   output logic                                        SRAM_UB_N
);

   localparam int BEATS = DATA_W / SRAM_DW;
   localparam int LB    = $clog2(BEATS);
   localparam int MW    = DATA_W / 8;

   if (SRAM_DW != 16 || BEATS < 2 || (BEATS & (BEATS - 1)) != 0 ||
       (DATA_W % SRAM_DW) != 0 || WAIT_CYC < 0 || WAIT_CYC > 7) begin : g_param_chk
      $error("sram_ctrl_param: unsupported parameter set");
   end

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETUP  = 3'd1,
      S_STROBE = 3'd2,
      S_RECOV  = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [MW-1:0]       r_bmask;
   logic                r_wr;
   logic [LB-1:0]       r_beat;
   logic [2:0]          r_cnt;
   logic [DATA_W-1:0]   r_rdbuf;
   logic [DATA_W-1:0]   r_rdata;

   logic                w_accept;
   logic                w_idle_or_done;
   logic                w_load_act;
   logic [LB:0]         w_in_first;
   logic [LB:0]         w_cur_first;
   logic [LB:0]         w_nxt_beat;
   logic                w_active;
   logic                w_dq_oe;
   logic [SRAM_DW-1:0]  w_dq_out;

`ifdef SRAM_CTRL_REQBUF_EN
   logic                r_buf_vld;
   logic [ADDR_W-1:0]   r_buf_addr;
   logic [DATA_W-1:0]   r_buf_wdata;
   logic [MW-1:0]       r_buf_bmask;
   logic                r_buf_wr;
   logic [LB:0]         w_buf_first;
   logic                w_load_buf;
   logic                w_drain_buf;
`endif

   // Returns {found, index} of the lowest beat >= start that has to run.
   // A read runs every beat. A write only runs beats with a byte enabled.
   function automatic logic [LB:0] pick_beat(input logic [MW-1:0] mask,
                                             input logic          is_wr,
                                             input int            start);
      logic [LB:0] res;
      res = '0;
      for (int k = BEATS - 1; k >= 0; k--) begin
         if (k >= start && (!is_wr || mask[2*k +: 2] != 2'b00))
            res = {1'b1, LB'(k)};
      end
      return res;
   endfunction

   assign w_idle_or_done = (r_state == S_IDLE) || (r_state == S_DONE);
   assign w_accept       = o_READY && (i_WREN || i_RDEN);
   assign w_load_act     = w_accept && w_idle_or_done;
   assign w_in_first     = pick_beat(i_BMASK, i_WREN, 0);
   assign w_cur_first    = pick_beat(r_bmask, r_wr, 0);
   assign w_nxt_beat     = pick_beat(r_bmask, r_wr, int'(r_beat) + 1);

`ifdef SRAM_CTRL_REQBUF_EN
   assign w_buf_first = pick_beat(r_buf_bmask, r_buf_wr, 0);
   assign w_load_buf  = w_accept && !w_idle_or_done;
   assign w_drain_buf = (r_state == S_DONE) && r_buf_vld;
`endif

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_accept) w_state_nxt = S_SETUP;
         S_SETUP:  w_state_nxt = w_cur_first[LB] ? S_STROBE : S_DONE;
         S_STROBE: if (r_cnt == 3'd0) w_state_nxt = S_RECOV;
         S_RECOV:  w_state_nxt = w_nxt_beat[LB] ? S_STROBE : S_DONE;
         S_DONE: begin
`ifdef SRAM_CTRL_REQBUF_EN
            if (r_buf_vld)
               w_state_nxt = w_buf_first[LB] ? S_STROBE : S_DONE;
            else
`endif
            if (w_accept)
               w_state_nxt = S_SETUP;
            else
               w_state_nxt = S_IDLE;
         end
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      o_ACK     = (r_state == S_DONE);
`ifdef SRAM_CTRL_REQBUF_EN
      o_READY   = !r_buf_vld;
`else
      o_READY   = w_idle_or_done;
`endif
      w_active  = (r_state == S_STROBE) || (r_state == S_RECOV);
      SRAM_CE_N = !w_active;
      SRAM_WE_N = !((r_state == S_STROBE) && r_wr);
      SRAM_OE_N = !((r_state == S_STROBE) && !r_wr);
      SRAM_LB_N = 1'b1;
      SRAM_UB_N = 1'b1;
      if (w_active) begin
         SRAM_LB_N = r_wr ? !r_bmask[2*int'(r_beat)]     : 1'b0;
         SRAM_UB_N = r_wr ? !r_bmask[2*int'(r_beat) + 1] : 1'b0;
      end
      w_dq_oe   = w_active && r_wr;
      w_dq_out  = r_wdata[int'(r_beat)*SRAM_DW +: SRAM_DW];
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_addr  <= '0;
         r_wdata <= '0;
         r_bmask <= '0;
         r_wr    <= 1'b0;
         r_beat  <= '0;
         r_cnt   <= '0;
         r_rdbuf <= '0;
         r_rdata <= '0;
      end else begin
         // The first beat is chosen at accept time. That way SETUP already
         // drives the correct address for the SRAM's address setup time.
         if (w_load_act) begin
            r_addr  <= i_ADDR;
            r_wdata <= i_WDATA;
            r_bmask <= i_BMASK;
            r_wr    <= i_WREN;
            r_beat  <= w_in_first[LB-1:0];
         end
`ifdef SRAM_CTRL_REQBUF_EN
         else if (w_drain_buf) begin
            r_addr  <= r_buf_addr;
            r_wdata <= r_buf_wdata;
            r_bmask <= r_buf_bmask;
            r_wr    <= r_buf_wr;
            r_beat  <= w_buf_first[LB-1:0];
         end
`endif
         else if (r_state == S_RECOV && w_nxt_beat[LB]) begin
            r_beat  <= w_nxt_beat[LB-1:0];
         end

         // Strobe timer: load WAIT_CYC on entry, the strobe ends at zero.
         if (w_state_nxt == S_STROBE && r_state != S_STROBE)
            r_cnt <= 3'(WAIT_CYC);
         else if (r_state == S_STROBE && r_cnt != 3'd0)
            r_cnt <= r_cnt - 3'd1;

         if (r_state == S_STROBE && r_cnt == 3'd0 && !r_wr)
            r_rdbuf[int'(r_beat)*SRAM_DW +: SRAM_DW] <= SRAM_DQ;

         if (r_state == S_RECOV && w_state_nxt == S_DONE && !r_wr)
            r_rdata <= r_rdbuf;
      end
   end

`ifdef SRAM_CTRL_REQBUF_EN
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_buf_vld   <= 1'b0;
         r_buf_addr  <= '0;
         r_buf_wdata <= '0;
         r_buf_bmask <= '0;
         r_buf_wr    <= 1'b0;
      end else if (w_load_buf) begin
         r_buf_vld   <= 1'b1;
         r_buf_addr  <= i_ADDR;
         r_buf_wdata <= i_WDATA;
         r_buf_bmask <= i_BMASK;
         r_buf_wr    <= i_WREN;
      end else if (w_drain_buf) begin
         r_buf_vld   <= 1'b0;
      end
   end
`endif

   assign o_RDATA   = r_rdata;
   assign SRAM_ADDR = {r_addr, r_beat};
   assign SRAM_DQ   = w_dq_oe ? w_dq_out : {SRAM_DW{1'bz}};

endmodule

// File: tb/tb_sram_ctrl_param.sv
// Bench for sram_ctrl_param (32b host word over a 16b SRAM, WAIT_CYC=1).
// The reference model works on whole host words kept in an associative array.
// Expected timing comes from the beat count and the wait-state arithmetic.
module tb_sram_ctrl_param;

   localparam int WC    = 1;
   localparam int BEATS = 2;
   localparam int MEMSZ = 1 << 18;
`ifdef SRAM_CTRL_REQBUF_EN
   localparam bit BUF = 1'b1;
`else
   localparam bit BUF = 1'b0;
`endif

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b0;
   logic [16:0] i_ADDR = '0;
   logic [31:0] i_WDATA = '0;
   logic [3:0]  i_BMASK = '0;
   logic        i_WREN = 1'b0;
   logic        i_RDEN = 1'b0;
   logic        o_READY;
   logic [31:0] o_RDATA;
   logic        o_ACK;
   logic [17:0] SRAM_ADDR;
   wire  [15:0] SRAM_DQ;
   logic        SRAM_CE_N, SRAM_WE_N, SRAM_OE_N, SRAM_LB_N, SRAM_UB_N;

   int n_vec = 0;
   int n_err = 0;
   int ce_cnt, we_cnt, oe_cnt, viol;
   logic [31:0] last_rdata = '0;
   logic [15:0] mem [0:MEMSZ-1];
   logic [31:0] hm [int];

   sram_ctrl_param #(.DATA_W(32), .SRAM_DW(16), .ADDR_W(17), .WAIT_CYC(WC)) u_dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_ADDR(i_ADDR), .i_WDATA(i_WDATA),
      .i_BMASK(i_BMASK), .i_WREN(i_WREN), .i_RDEN(i_RDEN), .o_READY(o_READY),
      .o_RDATA(o_RDATA), .o_ACK(o_ACK), .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(SRAM_DQ),
      .SRAM_CE_N(SRAM_CE_N), .SRAM_WE_N(SRAM_WE_N), .SRAM_OE_N(SRAM_OE_N),
      .SRAM_LB_N(SRAM_LB_N), .SRAM_UB_N(SRAM_UB_N)
   );

   always #5 i_clk = ~i_clk;

   // Asynchronous SRAM: drives data while CE and OE are low and WE is high.
   assign SRAM_DQ = (!SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) ? mem[SRAM_ADDR] : 16'bz;

   always @(negedge i_clk) begin
      if (!SRAM_CE_N) ce_cnt++;
      if (!SRAM_WE_N) we_cnt++;
      if (!SRAM_OE_N) oe_cnt++;
      if (!SRAM_WE_N && !SRAM_OE_N) viol++;
      if (SRAM_CE_N && (!SRAM_WE_N || !SRAM_OE_N || !SRAM_LB_N || !SRAM_UB_N)) viol++;
      if (!SRAM_CE_N && !SRAM_WE_N) begin
         if (!SRAM_LB_N) mem[SRAM_ADDR][7:0]  = SRAM_DQ[7:0];
         if (!SRAM_UB_N) mem[SRAM_ADDR][15:8] = SRAM_DQ[15:8];
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] init_hw(input int i);
      return 16'((i * 40503) ^ 23130);
   endfunction

   function automatic logic [31:0] model_rd(input int a);
      if (hm.exists(a)) return hm[a];
      return {init_hw(2*a + 1), init_hw(2*a)};
   endfunction

   task automatic model_wr(input int a, input logic [31:0] wd, input logic [3:0] m);
      logic [31:0] w;
      w = model_rd(a);
      for (int b = 0; b < 4; b++)
         if (m[b]) w[8*b +: 8] = wd[8*b +: 8];
      hm[a] = w;
   endtask

   task automatic do_req(input bit wr, input bit rd, input logic [16:0] a,
                         input logic [31:0] wd, input logic [3:0] m, input bit poke);
      int n, lat, cyc;
      logic [31:0] exp_rd;
      logic [31:0] w;
      @(negedge i_clk);
      chk("ready_pre", o_READY, 1);
      i_ADDR = a; i_WDATA = wd; i_BMASK = m; i_WREN = wr; i_RDEN = rd;
      n = 0;
      if (wr) begin
         for (int k = 0; k < BEATS; k++)
            if (m[2*k +: 2] != 2'b00) n++;
      end else begin
         n = BEATS;
      end
      lat = n * (WC + 2) + 1;
      exp_rd = wr ? last_rdata : model_rd(int'(a));
      if (wr) model_wr(int'(a), wd, m);
      @(posedge i_clk); #1;
      i_WREN = 1'b0; i_RDEN = 1'b0;
      i_ADDR = 17'($urandom); i_WDATA = $urandom; i_BMASK = 4'($urandom);
      ce_cnt = 0; we_cnt = 0; oe_cnt = 0; viol = 0;
      chk("ready_e0", o_READY, BUF);
      cyc = 0;
      while (cyc < 100) begin
         @(posedge i_clk); #1;
         cyc++;
         if (o_ACK) break;
         chk("ready_busy", o_READY, BUF);
         if (poke && !BUF && cyc == 2) begin
            i_WREN = 1'b1; i_ADDR = a; i_BMASK = 4'hF; i_WDATA = ~wd;
         end
         if (cyc == 3) i_WREN = 1'b0;
      end
      chk("ack_lat", cyc, lat);
      chk("ready_done", o_READY, 1);
      chk("rdata", o_RDATA, exp_rd);
      chk("ce_cycles", ce_cnt, n * (WC + 2));
      chk("we_cycles", we_cnt, wr ? n * (WC + 1) : 0);
      chk("oe_cycles", oe_cnt, wr ? 0 : n * (WC + 1));
      chk("pin_viol", viol, 0);
      if (wr) begin
         w = model_rd(int'(a));
         chk("mem_lo", mem[{a, 1'b0}], w[15:0]);
         chk("mem_hi", mem[{a, 1'b1}], w[31:16]);
      end else begin
         last_rdata = exp_rd;
      end
   endtask

   task automatic reset_state_chk(input string tag);
      chk({tag, "_ce"}, SRAM_CE_N, 1);
      chk({tag, "_we"}, SRAM_WE_N, 1);
      chk({tag, "_oe"}, SRAM_OE_N, 1);
      chk({tag, "_lbub"}, {SRAM_LB_N, SRAM_UB_N}, 2'b11);
      chk({tag, "_addr"}, SRAM_ADDR, 0);
      chk({tag, "_rdata"}, o_RDATA, 0);
      chk({tag, "_ack"}, o_ACK, 0);
      chk({tag, "_ready"}, o_READY, 1);
   endtask

   initial begin
      int op, gap;
      logic [16:0] ra;
      for (int i = 0; i < MEMSZ; i++) mem[i] = init_hw(i);

      #12;
      reset_state_chk("rst");
      @(negedge i_clk); i_reset = 1'b1;

      do_req(1, 0, 17'd0, 32'h12345678, 4'hF, 0);
      chk("t1_mem0", mem[0], 16'h5678);
      chk("t1_mem1", mem[1], 16'h1234);
      do_req(0, 1, 17'd0, 32'h0, 4'h0, 0);
      chk("t2_rdata", o_RDATA, 32'h12345678);

      do_req(1, 0, 17'd3, 32'hAABBCCDD, 4'b0100, 0);
      chk("t3_mem6", mem[6], init_hw(6));
      chk("t3_mem7", mem[7], {init_hw(7) >> 8, 8'hBB});

      do_req(1, 0, 17'd9, 32'hDEADBEEF, 4'h0, 0);
      do_req(1, 1, 17'd9, 32'hCAFEF00D, 4'hF, 0);
      do_req(0, 1, 17'd9, 32'h0, 4'h0, 1);

      // Reset asserted during the first strobe cycle of beat 1 of a read.
      @(negedge i_clk);
      i_ADDR = 17'd5; i_RDEN = 1'b1;
      @(posedge i_clk); #1;
      i_RDEN = 1'b0;
      repeat (1 + (WC + 2)) @(posedge i_clk);
      #1;
      chk("mid_oe", SRAM_OE_N, 0);
      chk("mid_addr", SRAM_ADDR, {17'd5, 1'b1});
      i_reset = 1'b0;
      #1;
      reset_state_chk("mid_rst");
      repeat (3) begin
         @(posedge i_clk); #1;
         chk("rst_hold_ack", o_ACK, 0);
      end
      @(negedge i_clk); i_reset = 1'b1;
      last_rdata = '0;
      #1 chk("post_rst_ready", o_READY, 1);
      do_req(0, 1, 17'd5, 32'h0, 4'h0, 0);

      for (int t = 0; t < 60; t++) begin
         op  = int'($urandom_range(0, 3));
         ra  = ($urandom_range(0, 7) == 0) ? 17'($urandom) : 17'($urandom_range(0, 15));
         gap = int'($urandom_range(0, 2));
         repeat (gap) @(negedge i_clk);
         do_req(op != 2, op >= 2, ra, $urandom, 4'($urandom), $urandom_range(0, 1) == 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
